// File: rtl/up_down_counter_pkg.sv
// up_down_counter_pkg
//   Shared encodings and helpers for the up/down counter family.
//   - dir_e  : counting direction (UP = 1, DOWN = 0)
//   - mode_e : boundary behaviour (WRAP = 0, SAT = 1)
//   - clog2  : ceil(log2(v)), used to size the prescaler counter
package up_down_counter_pkg;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_e;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 32'd0;
    x = 32'd1;
    while (x < v) begin
      x = x << 1;
      r = r + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/up_down_counter_mod_tick_prescaler.sv
// tick_prescaler
//   Divides enabled clock cycles down to one Tick every PRESCALE enabled
//   cycles. The phase counter advances only while En = 1 and is cleared
//   by Clear (synchronous) or reset (asynchronous). For PRESCALE = 1 the
//   Tick is constantly 1 and no registers are built.
// Ports:
//   Clk   in  rising-edge clock
//   reset in  asynchronous active-high reset
//   En    in  advance enable; En = 0 freezes the phase
//   Clear in  synchronous clear of the phase counter
//   Tick  out 1 while the phase counter sits at PRESCALE-1
module tick_prescaler
  import up_down_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic Clk,
  input  logic reset,
  input  logic En,
  input  logic Clear,
  output logic Tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // Inputs are intentionally unused when no division is required
      logic unused_s;
      assign unused_s = &{1'b0, Clk, reset, En, Clear};
      assign Tick     = 1'b1;
    end else begin : g_div
      localparam int unsigned PW = clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0] ONE  = PW'(1);
      localparam logic [PW-1:0] ZERO = PW'(0);

      logic [PW-1:0] phase_r;
      logic [PW-1:0] phase_nxt_s;

      // Next phase: clear wins, otherwise advance and roll over at LAST
      always_comb begin
        phase_nxt_s = phase_r;
        if (Clear) begin
          phase_nxt_s = ZERO;
        end else if (En) begin
          if (phase_r == LAST) begin
            phase_nxt_s = ZERO;
          end else begin
            phase_nxt_s = phase_r + ONE;
          end
        end else begin
          phase_nxt_s = phase_r;
        end
      end

      // Phase register
      always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
          phase_r <= ZERO;
        end else begin
          phase_r <= phase_nxt_s;
        end
      end

      assign Tick = (phase_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod
//   WIDTH-generic up/down counter with programmable terminal value
//   (range 0..Limit), wrap or saturate mode, synchronous load, count
//   enable, a clock prescaler, and registered Wrap/Sat status.
// Ports:
//   Clk       in  rising-edge clock
//   reset     in  asynchronous active-high reset
//   En        in  count enable (gates prescaler and step)
//   UpOrDown  in  1 = up, 0 = down
//   Load      in  synchronous load strobe (wins over a step)
//   LoadValue in  value to load, clipped to Limit
//   Limit     in  terminal value
//   SatMode   in  1 = saturate at the boundary, 0 = wrap
//   Count     out current count (registered)
//   Wrap      out one-cycle pulse in the cycle Count shows a wrapped value
//   Sat       out high while Count is held at a boundary by SatMode
module up_down_counter_mod
  import up_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic [WIDTH-1:0] Limit,
  input  logic             SatMode,
  output logic [WIDTH-1:0] Count,
  output logic             Wrap,
  output logic             Sat
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             tick_s;
  logic             step_s;
  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             sat_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic             sat_nxt_s;
  logic             at_limit_s;
  logic             at_zero_s;
  logic             over_s;
  logic [WIDTH-1:0] load_clip_s;

  // Load restarts the prescaler so the next step needs a full period
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .Clk  (Clk),
    .reset(reset),
    .En   (En),
    .Clear(Load),
    .Tick (tick_s)
  );

  assign step_s      = En & tick_s;
  assign at_limit_s  = (count_r == Limit);
  assign at_zero_s   = (count_r == ZERO);
  assign over_s      = (count_r > Limit);
  assign load_clip_s = (LoadValue > Limit) ? Limit : LoadValue;

  // Next-count mux: Load > step > hold, with boundary wrap/saturate
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    sat_nxt_s   = sat_r;
    if (Load) begin
      count_nxt_s = load_clip_s;
      sat_nxt_s   = 1'b0;
    end else if (step_s) begin
      if (over_s) begin
        // Limit was lowered below Count: snap back into range quietly
        count_nxt_s = Limit;
        sat_nxt_s   = 1'b0;
      end else if (UpOrDown == UP) begin
        if (!at_limit_s) begin
          count_nxt_s = count_r + ONE;
          sat_nxt_s   = 1'b0;
        end else if (SatMode == SAT) begin
          count_nxt_s = count_r;
          sat_nxt_s   = 1'b1;
        end else begin
          count_nxt_s = ZERO;
          wrap_nxt_s  = 1'b1;
          sat_nxt_s   = 1'b0;
        end
      end else begin
        if (!at_zero_s) begin
          count_nxt_s = count_r - ONE;
          sat_nxt_s   = 1'b0;
        end else if (SatMode == SAT) begin
          count_nxt_s = count_r;
          sat_nxt_s   = 1'b1;
        end else begin
          count_nxt_s = Limit;
          wrap_nxt_s  = 1'b1;
          sat_nxt_s   = 1'b0;
        end
      end
    end else begin
      // No step: Count and Sat hold, Wrap drops
      count_nxt_s = count_r;
      sat_nxt_s   = sat_r;
    end
  end

  // Count and status registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO;
      wrap_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  assign Count = count_r;
  assign Wrap  = wrap_r;
  assign Sat   = sat_r;

endmodule

// File: tb/tb_up_down_counter_mod.sv
module tb_up_down_counter_mod;

  logic       Clk;
  logic       reset;
  logic       En;
  logic       UpOrDown;
  logic       Load;
  logic [3:0] LoadValue;
  logic [3:0] Limit;
  logic       SatMode;
  logic [3:0] Count;
  logic       Wrap;
  logic       Sat;
  logic [3:0] Count3;
  logic       Wrap3;
  logic       Sat3;

  int tests;
  int fails;

  up_down_counter_mod #(.WIDTH(4), .PRESCALE(1)) dut (
    .Clk(Clk), .reset(reset), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadValue(LoadValue), .Limit(Limit), .SatMode(SatMode),
    .Count(Count), .Wrap(Wrap), .Sat(Sat)
  );

  up_down_counter_mod #(.WIDTH(4), .PRESCALE(3)) dut_p3 (
    .Clk(Clk), .reset(reset), .En(En), .UpOrDown(UpOrDown), .Load(Load),
    .LoadValue(LoadValue), .Limit(Limit), .SatMode(SatMode),
    .Count(Count3), .Wrap(Wrap3), .Sat(Sat3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; En = 1'b0; UpOrDown = 1'b1; Load = 1'b0;
    LoadValue = 4'd0; Limit = 4'd15; SatMode = 1'b0;
    tick();
    tests++;
    if ({Count, Wrap, Sat} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset: got count=%0d wrap=%0b sat=%0b, want 0 0 0", Count, Wrap, Sat);
      fails++;
    end
    tests++;
    if ({Count3, Wrap3, Sat3} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_p3: got count=%0d wrap=%0b sat=%0b, want 0 0 0", Count3, Wrap3, Sat3);
      fails++;
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_c;
    logic       exp_w;
    En = 1'b1; UpOrDown = 1'b1; Limit = 4'd15; SatMode = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_c = 4'(i % 16);
      exp_w = (i == 16);
      tests++;
      if ({Count, Wrap, Sat} !== {exp_c, exp_w, 1'b0}) begin
        $display("FAIL wrap_up[%0d]: got count=%0d wrap=%0b sat=%0b, want %0d %0b 0",
                 i, Count, Wrap, Sat, exp_c, exp_w);
        fails++;
      end
    end
  endtask

  task automatic test_wrap_down();
    logic [3:0] exp_c [4];
    logic       exp_w [4];
    exp_c = '{4'd1, 4'd0, 4'd9, 4'd8};
    exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
    Limit = 4'd9; Load = 1'b1; LoadValue = 4'd2; UpOrDown = 1'b0;
    tick();
    tests++;
    if (Count !== 4'd2) begin
      $display("FAIL load2: got count=%0d, want 2", Count);
      fails++;
    end
    Load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({Count, Wrap} !== {exp_c[i], exp_w[i]}) begin
        $display("FAIL wrap_down[%0d]: got count=%0d wrap=%0b, want %0d %0b",
                 i, Count, Wrap, exp_c[i], exp_w[i]);
        fails++;
      end
    end
  endtask

  task automatic test_saturate();
    logic exp_s [3];
    exp_s = '{1'b0, 1'b1, 1'b1};
    Limit = 4'd9; Load = 1'b1; LoadValue = 4'd8; UpOrDown = 1'b1; SatMode = 1'b1;
    tick();
    Load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({Count, Wrap, Sat} !== {4'd9, 1'b0, exp_s[i]}) begin
        $display("FAIL sat_up[%0d]: got count=%0d wrap=%0b sat=%0b, want 9 0 %0b",
                 i, Count, Wrap, Sat, exp_s[i]);
        fails++;
      end
    end
    En = 1'b0;
    tick();
    tests++;
    if ({Count, Sat} !== {4'd9, 1'b1}) begin
      $display("FAIL sat_hold_en0: got count=%0d sat=%0b, want 9 1", Count, Sat);
      fails++;
    end
    En = 1'b1; UpOrDown = 1'b0;
    tick();
    tests++;
    if ({Count, Sat} !== {4'd8, 1'b0}) begin
      $display("FAIL sat_release: got count=%0d sat=%0b, want 8 0", Count, Sat);
      fails++;
    end
    // Saturate at zero going down
    Load = 1'b1; LoadValue = 4'd0;
    tick();
    Load = 1'b0;
    tick();
    tests++;
    if ({Count, Wrap, Sat} !== {4'd0, 1'b0, 1'b1}) begin
      $display("FAIL sat_down: got count=%0d wrap=%0b sat=%0b, want 0 0 1", Count, Wrap, Sat);
      fails++;
    end
  endtask

  task automatic test_out_of_range();
    SatMode = 1'b0; Limit = 4'd15; UpOrDown = 1'b1; Load = 1'b1; LoadValue = 4'd12;
    tick();
    Load = 1'b0; Limit = 4'd5;
    tick();
    tests++;
    if ({Count, Wrap, Sat} !== {4'd5, 1'b0, 1'b0}) begin
      $display("FAIL oor_up: got count=%0d wrap=%0b sat=%0b, want 5 0 0", Count, Wrap, Sat);
      fails++;
    end
    Limit = 4'd15; Load = 1'b1; LoadValue = 4'd13; SatMode = 1'b1; UpOrDown = 1'b0;
    tick();
    Load = 1'b0; Limit = 4'd5;
    tick();
    tests++;
    if ({Count, Wrap, Sat} !== {4'd5, 1'b0, 1'b0}) begin
      $display("FAIL oor_down_sat: got count=%0d wrap=%0b sat=%0b, want 5 0 0", Count, Wrap, Sat);
      fails++;
    end
    Load = 1'b1; LoadValue = 4'd14;
    tick();
    Load = 1'b0;
    tests++;
    if (Count !== 4'd5) begin
      $display("FAIL load_clip: got count=%0d, want 5", Count);
      fails++;
    end
  endtask

  task automatic test_limit_zero();
    Limit = 4'd0; SatMode = 1'b0; Load = 1'b1; LoadValue = 4'd3;
    tick();
    Load = 1'b0; UpOrDown = 1'b1;
    tick();
    tests++;
    if ({Count, Wrap} !== {4'd0, 1'b1}) begin
      $display("FAIL lim0_up: got count=%0d wrap=%0b, want 0 1", Count, Wrap);
      fails++;
    end
    UpOrDown = 1'b0;
    tick();
    tests++;
    if ({Count, Wrap} !== {4'd0, 1'b1}) begin
      $display("FAIL lim0_down: got count=%0d wrap=%0b, want 0 1", Count, Wrap);
      fails++;
    end
    En = 1'b0;
    tick();
    tests++;
    if ({Count, Wrap} !== {4'd0, 1'b0}) begin
      $display("FAIL lim0_idle: got count=%0d wrap=%0b, want 0 0", Count, Wrap);
      fails++;
    end
  endtask

  task automatic test_prescaler();
    logic       en_seq [4];
    logic [3:0] exp_c  [4];
    en_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_c  = '{4'd0, 4'd0, 4'd0, 4'd1};
    Limit = 4'd15; SatMode = 1'b0; UpOrDown = 1'b1;
    En = 1'b0; Load = 1'b1; LoadValue = 4'd0;
    tick();
    Load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      En = en_seq[i];
      tick();
      tests++;
      if (Count3 !== exp_c[i]) begin
        $display("FAIL presc_en[%0d]: got count=%0d, want %0d", i, Count3, exp_c[i]);
        fails++;
      end
    end
    En = 1'b1;
    tick();
    tick();
    // Prescaler now at its tick phase; Load must discard the step
    Load = 1'b1; LoadValue = 4'd7;
    tick();
    Load = 1'b0;
    tests++;
    if (Count3 !== 4'd7) begin
      $display("FAIL presc_load: got count=%0d, want 7", Count3);
      fails++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (Count3 !== ((i == 2) ? 4'd8 : 4'd7)) begin
        $display("FAIL presc_restart[%0d]: got count=%0d, want %0d",
                 i, Count3, (i == 2) ? 8 : 7);
        fails++;
      end
    end
  endtask

  task automatic test_async_reset();
    Limit = 4'd7; SatMode = 1'b1; UpOrDown = 1'b1; En = 1'b1;
    Load = 1'b1; LoadValue = 4'd6;
    tick();
    Load = 1'b0;
    tick();
    tick();
    tests++;
    if ({Count, Sat} !== {4'd7, 1'b1}) begin
      $display("FAIL pre_reset: got count=%0d sat=%0b, want 7 1", Count, Sat);
      fails++;
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({Count, Wrap, Sat} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL async_reset: got count=%0d wrap=%0b sat=%0b, want 0 0 0", Count, Wrap, Sat);
      fails++;
    end
    tick();
    tick();
    tests++;
    if (Count !== 4'd0) begin
      $display("FAIL reset_hold: got count=%0d, want 0", Count);
      fails++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (Count3 !== ((i == 2) ? 4'd1 : 4'd0)) begin
        $display("FAIL post_reset_p3[%0d]: got count=%0d, want %0d",
                 i, Count3, (i == 2) ? 1 : 0);
        fails++;
      end
    end
    tests++;
    if (Count !== 4'd3) begin
      $display("FAIL post_reset_p1: got count=%0d, want 3", Count);
      fails++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_out_of_range();
    test_limit_zero();
    test_prescaler();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/up_down_counter_mod.md
# up_down_counter_mod

Parametrised synchronous up/down counter, the WIDTH-generic successor of the fixed 4-bit up/down counter. It adds a programmable terminal value (modulus), wrap or saturate mode, synchronous load, count enable, a clock prescaler, and registered wrap/saturate status. It serves as a general event/timebase counter for timers, PWM periods and address sequencers.

## Interface
- WIDTH, 4: counter width in bits (≥ 2).
- PRESCALE, 1: enabled clocks per count step (≥ 1); 1 means step every enabled cycle.
- Clk  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- En  in  1  count enable; gates both the prescaler and the count step.
- UpOrDown  in  1  1 = count up, 0 = count down; sampled at each step.
- Load  in  1  synchronous load strobe.
- LoadValue  in  WIDTH  value loaded when Load = 1.
- Limit  in  WIDTH  terminal value; count range is 0..Limit inclusive.
- SatMode  in  1  1 = saturate at the boundary, 0 = wrap.
- Count  out  WIDTH  current count (registered).
- Wrap  out  1  registered one-cycle pulse in the cycle Count shows a wrapped value.
- Sat  out  1  registered; high while Count is held at a boundary by SatMode.

## Operation
- Priority per rising Clk edge: reset (async) > Load > step > hold.
- Step occurs when En = 1 and the prescaler tick is 1. With PRESCALE = 1 the tick is constantly 1.
- Up step: Count < Limit -> Count + 1. Count == Limit -> 0 with Wrap = 1 (SatMode = 0), or hold with Sat = 1 (SatMode = 1).
- Down step: Count > 0 -> Count − 1. Count == 0 -> Limit with Wrap = 1 (SatMode = 0), or hold with Sat = 1 (SatMode = 1).
- Out of range (Count > Limit, after Limit is lowered): the next step forces Count = Limit in either direction and mode. No Wrap pulse; Sat = 0.
- Load: Count ← min(LoadValue, Limit). Prescaler counter clears to 0. Wrap = 0, Sat = 0. Load ignores En.
- Sat clears on the first step that moves Count, on Load, or on reset. It stays high while En = 0.
- Wrap is high for exactly one cycle per wrap. It is 0 in any cycle without a wrapping step.
- Arithmetic is WIDTH-bit unsigned. Limit = 2^WIDTH − 1 gives natural binary roll-over. Limit = 0 holds Count at 0 and pulses Wrap on every step when SatMode = 0.
- UpOrDown and SatMode may change in any cycle and take effect at the next step. The prescaler phase is unaffected.

## Timing
- Reset values: Count = 0, Wrap = 0, Sat = 0, prescaler = 0.
- Reset asserted mid-count clears all outputs asynchronously. The first step after release needs a full PRESCALE enabled cycles.
- Latency: Count, Wrap and Sat update on the same edge as the step or load. No combinational paths from inputs to outputs.
- Prescaler: a ceil(log2(PRESCALE))-bit counter advances only while En = 1. Tick = 1 when it equals PRESCALE − 1; it then returns to 0. En = 0 freezes its phase.
- Load and step in the same cycle: Load wins and the step is discarded.

## Structure
- Shared package up_down_counter_pkg: the direction encodings (UP = 1, DOWN = 0) and mode encodings (WRAP = 0, SAT = 1), plus a clog2 helper function for the prescaler width.
- One sub-module is natural: tick_prescaler (Clk, reset, En, Clear → Tick), parametrised by PRESCALE. For PRESCALE = 1 it generates constant Tick = 1 with no registers.
- The top level holds the next-count mux, the range comparators, and the Wrap/Sat registers.

## Test plan
- WIDTH = 4, Limit = 15, SatMode = 0, En = 1, up, 20 cycles after reset -> Count runs 1..15, 0, 1..4. Wrap pulses exactly once, in the cycle Count = 0.
- Limit = 9, down, SatMode = 0, starting from Load 2 -> Count 1, 0, 9, 8. Wrap is high only in the cycle showing 9.
- Limit = 9, up, SatMode = 1, Load 8 -> Count 9, 9, 9 with Sat = 1 from the first hold. Switching to down -> Count 8 and Sat = 0.
- PRESCALE = 3, up, En toggles 1,1,0,1 -> first step occurs after the third enabled cycle. Load in a tick cycle -> Count = LoadValue, step discarded, prescaler restarts at 0.
- Count = 12, Limit changed to 5, step -> Count = 5, no Wrap. Load 14 with Limit = 5 -> Count = 5.
- reset asserted mid-count while Count = 7, Sat = 1 -> Count = 0 and Sat = 0 before the next Clk edge. Count holds 0 until reset is released.
